lab7_1soc_keys_pio: RTL and testbench

Avalon-MM slave input PIO for the board push-buttons, the read-side counterpart of the LED output PIO on the same SoC interconnect. It synchronizes and debounces `in_port`, latches falling edges (button presses) into a write-1-to-clear edge-capture register, and raises a level interrupt through a mask register. The Nios II reads key state and press events from it.

---
 rtl/lab7_1soc_keys_pio_if.sv | 19 +
 rtl/lab7_1soc_keys_pio.sv | 109 ++++++++++
 tb/tb_lab7_1soc_keys_pio.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lab7_1soc_keys_pio_if.sv
// Avalon-MM slave bus for the key PIO: register access plus the interrupt line.
interface lab7_1soc_keys_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/lab7_1soc_keys_pio.sv
// Input PIO for push-buttons: per-bit synchronizer and debouncer, falling-edge
// capture (write-1-to-clear), irq mask and a level interrupt.

// One key bit: 2-flop synchronizer followed by a stable-count debouncer.
module lab7_1soc_keys_pio_lane #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic db,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // A level change is accepted on the edge where the counter has seen enough
    // consecutive differing samples.
    assign accept = (sync2 != db) && (cnt == CNT_MAX);
    // db is 1 and about to become 0: a key press.
    assign fall   = accept && db;

    // Synchronize, then track how long sync2 has disagreed with db.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            db    <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (accept) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module lab7_1soc_keys_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    lab7_1soc_keys_pio_if.slave      bus,
    input  logic [WIDTH-1:0]         in_port
);
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic             wr;
    logic             unused_wdata;

    // Upper writedata bits have no register behind them.
    assign unused_wdata = ^bus.writedata;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            lab7_1soc_keys_pio_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .in_bit  (in_port[i]),
                .db      (db[i]),
                .fall    (fall[i])
            );
        end
    endgenerate

    assign wr      = bus.chipselect && !bus.write_n;
    assign cap_clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    // Mask register and edge capture; a new press beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr && bus.address == 2'd2)
                irq_mask <= bus.writedata[WIDTH-1:0];
            edge_cap <= (edge_cap & ~cap_clr) | fall;
        end
    end

    // Read mux is combinational and ignores chipselect; direction reads as 0.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = 32'(db);
            2'd2:    bus.readdata = 32'(irq_mask);
            2'd3:    bus.readdata = 32'(edge_cap);
            default: bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_lab7_1soc_keys_pio.sv
// Directed bench for the key PIO with a queue-based expected-value scoreboard.
module tb_lab7_1soc_keys_pio;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'h0;

    lab7_1soc_keys_pio_if bus ();

    lab7_1soc_keys_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        is_irq;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pop the oldest expectation and compare it against the live DUT output.
    task automatic compare_front();
        exp_t        x;
        logic [31:0] got;
        x   = sb.pop_front();
        got = x.is_irq ? {31'b0, bus.irq} : bus.readdata;
        checks++;
        assert (got === x.exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", x.tag, got, x.exp);
        end
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [31:0] e, input string tag);
        bus.address = a;
        sb.push_back('{tag: tag, is_irq: 1'b0, exp: e});
        #1;
        compare_front();
    endtask

    task automatic expect_irq(input logic e, input string tag);
        sb.push_back('{tag: tag, is_irq: 1'b1, exp: {31'b0, e}});
        #1;
        compare_front();
    endtask

    // One-cycle bus write; the register updates on the edge ending the cycle.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset with keys held low: debounced state still reads idle-high.
        tick(3);
        expect_irq(1'b0, "rst_irq");
        expect_rd(2'd0, 32'h0000_000F, "rst_data");
        expect_rd(2'd1, 32'h0, "rst_dir");
        expect_rd(2'd2, 32'h0, "rst_mask");
        expect_rd(2'd3, 32'h0, "rst_cap");
        in_port = 4'hF;
        tick();
        reset_n = 1'b1;
        tick(8);

        // Press key 0: sampled at edge 0, db flips at edge 5.
        in_port = 4'hE;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            expect_rd(2'd0, 32'h0000_000F, $sformatf("press_early_e%0d", e));
        end
        tick();
        expect_rd(2'd0, 32'h0000_000E, "press_data");
        expect_rd(2'd3, 32'h0000_0001, "press_cap");
        expect_irq(1'b0, "press_irq_masked");

        // Release is not captured.
        in_port = 4'hF;
        tick(10);
        expect_rd(2'd0, 32'h0000_000F, "release_data");
        expect_rd(2'd3, 32'h0000_0001, "release_cap");
        bus_wr(2'd3, 32'h1);
        expect_rd(2'd3, 32'h0, "clear_cap");

        // Short glitch on key 2 is rejected.
        in_port = 4'hB;
        tick(3);
        in_port = 4'hF;
        tick(10);
        expect_rd(2'd0, 32'h0000_000F, "glitch3_data");
        expect_rd(2'd3, 32'h0, "glitch3_cap");

        // Longer pulse on key 2 is accepted as a press.
        in_port = 4'hB;
        tick(6);
        in_port = 4'hF;
        tick(12);
        expect_rd(2'd3, 32'h0000_0004, "pulse6_cap");
        expect_rd(2'd0, 32'h0000_000F, "pulse6_released");

        // Another key-0 press to build edge_cap = 5.
        in_port = 4'hE;
        tick(8);
        in_port = 4'hF;
        tick(10);
        expect_rd(2'd3, 32'h0000_0005, "cap5");

        // Interrupt path through the mask.
        bus_wr(2'd2, 32'h4);
        expect_rd(2'd2, 32'h0000_0004, "mask4");
        expect_irq(1'b1, "irq_mask4");
        bus_wr(2'd3, 32'h4);
        expect_irq(1'b0, "irq_cleared");
        expect_rd(2'd3, 32'h0000_0001, "cap_after_clr4");
        bus_wr(2'd2, 32'h1);
        expect_irq(1'b1, "irq_mask1");
        bus_wr(2'd2, 32'hFFFF_FFF0);
        expect_rd(2'd2, 32'h0, "mask_upper_ignored");
        expect_irq(1'b0, "irq_unmasked");
        bus_wr(2'd2, 32'h1);

        // Collision: clear-all lands on the edge key 1 is captured.
        in_port = 4'hD;
        tick(5);
        bus_wr(2'd3, 32'hF);
        expect_rd(2'd3, 32'h0000_0002, "collide_cap");
        expect_rd(2'd0, 32'h0000_000D, "collide_data");
        expect_irq(1'b0, "collide_irq");

        // Writes to data and direction are ignored.
        bus_wr(2'd0, 32'h0);
        expect_rd(2'd0, 32'h0000_000D, "data_wr_ignored");
        bus_wr(2'd1, 32'hFFFF_FFFF);
        expect_rd(2'd1, 32'h0, "dir_wr_ignored");

        // Reset with a pending capture drops it.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        in_port = 4'hF;
        #1;
        expect_rd(2'd3, 32'h0, "rst_drops_cap");
        expect_rd(2'd0, 32'h0000_000F, "rst_db_high");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
